// File: rtl/hwpe_stream_package.sv
// Shared definitions for the hwpe_stream FIFO family: occupancy flags struct
// and the counter width it is built on.
package hwpe_stream_package;

    localparam int unsigned FIFO_CNT_W = 16;

    typedef struct packed {
        logic                  empty;
        logic                  full;
        logic [FIFO_CNT_W-1:0] count;
    } fifo_flags_t;

endpackage

// File: rtl/hwpe_stream_fifo_scm_ctrl.sv
// Controller for a FIFO backed by a 1R1W latch SCM (2-cycle fall-through).
// Optional synchronous clear input enabled by HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN.
module hwpe_stream_fifo_scm_ctrl
    import hwpe_stream_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN
    input  logic                  clear_i,
`endif
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic                  scm_we_o,
    output logic [ADDR_WIDTH-1:0] scm_waddr_o,
    output logic [DATA_WIDTH-1:0] scm_wdata_o,
    output logic                  scm_re_o,
    output logic [ADDR_WIDTH-1:0] scm_raddr_o,
    input  logic [DATA_WIDTH-1:0] scm_rdata_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [FIFO_CNT_W-1:0] DEPTH_CNT = FIFO_CNT_W'(DEPTH);
    localparam logic [FIFO_CNT_W-1:0] CNT_ZERO  = {FIFO_CNT_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  pop_valid_q, pop_valid_d;
    fifo_flags_t           flags_q, flags_d;

    logic [FIFO_CNT_W-1:0] unread_s;
    logic [FIFO_CNT_W-1:0] count_s;
    logic                  clear_s;
    logic                  push_ready_s;
    logic                  push_hs_s;
    logic                  pop_hs_s;
    logic                  read_issue_s;

`ifdef HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN
    assign clear_s = clear_i;
`else
    assign clear_s = 1'b0;
`endif

    // Ready looks only at stored occupancy, so a pop never frees a slot for a same-cycle push.
    assign push_ready_s = (flags_q.count < DEPTH_CNT) & ~clear_s;
    assign push_hs_s    = push_valid_i & push_ready_s & ~rst;
    assign pop_hs_s     = pop_valid_q & pop_ready_i & ~clear_s;
    assign unread_s     = flags_q.count - FIFO_CNT_W'(pop_valid_q);
    assign read_issue_s = (unread_s != CNT_ZERO) & (~pop_valid_q | pop_ready_i) & ~clear_s;

    // Next-state: pointers, occupancy, output-valid and registered flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pop_valid_d = pop_valid_q;
        count_s     = flags_q.count;
        if (clear_s) begin
            wr_ptr_d    = {ADDR_WIDTH{1'b0}};
            rd_ptr_d    = {ADDR_WIDTH{1'b0}};
            pop_valid_d = 1'b0;
            count_s     = CNT_ZERO;
        end else begin
            if (push_hs_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (read_issue_s) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                pop_valid_d = 1'b1;
            end else if (pop_hs_s) begin
                pop_valid_d = 1'b0;
            end else begin
                pop_valid_d = pop_valid_q;
            end
            // Slots are released only by the pop handshake, never by read issue.
            case ({push_hs_s, pop_hs_s})
                2'b10:   count_s = flags_q.count + FIFO_CNT_W'(1);
                2'b01:   count_s = flags_q.count - FIFO_CNT_W'(1);
                default: count_s = flags_q.count;
            endcase
        end
        flags_d.count = count_s;
        flags_d.empty = (count_s == CNT_ZERO);
        flags_d.full  = (count_s == DEPTH_CNT);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q      <= {ADDR_WIDTH{1'b0}};
            pop_valid_q   <= 1'b0;
            flags_q.count <= CNT_ZERO;
            flags_q.empty <= 1'b1;
            flags_q.full  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pop_valid_q <= pop_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign push_ready_o = push_ready_s;
    assign scm_we_o     = push_hs_s;
    assign scm_waddr_o  = wr_ptr_q;
    assign scm_wdata_o  = push_data_i;
    assign scm_re_o     = read_issue_s;
    assign scm_raddr_o  = rd_ptr_q;
    assign pop_data_o   = scm_rdata_i;
    assign pop_valid_o  = pop_valid_q;
    assign count_o      = flags_q.count[ADDR_WIDTH:0];
    assign empty_o      = flags_q.empty;
    assign full_o       = flags_q.full;

endmodule

// File: tb/tb_hwpe_stream_fifo_scm_ctrl.sv
// Directed self-checking bench for hwpe_stream_fifo_scm_ctrl at DEPTH=4,
// with a behavioural 1R1W SCM attached to the memory port.
module tb_hwpe_stream_fifo_scm_ctrl;

    localparam int AW = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN
    logic          clear_i;
`endif
    logic [DW-1:0] push_data;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          pop_ready;
    logic          scm_we;
    logic [AW-1:0] scm_waddr;
    logic [DW-1:0] scm_wdata;
    logic          scm_re;
    logic [AW-1:0] scm_raddr;
    logic [DW-1:0] scm_rdata;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    hwpe_stream_fifo_scm_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN
        .clear_i      (clear_i),
`endif
        .push_data_i  (push_data),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .pop_data_o   (pop_data),
        .pop_valid_o  (pop_valid),
        .pop_ready_i  (pop_ready),
        .scm_we_o     (scm_we),
        .scm_waddr_o  (scm_waddr),
        .scm_wdata_o  (scm_wdata),
        .scm_re_o     (scm_re),
        .scm_raddr_o  (scm_raddr),
        .scm_rdata_i  (scm_rdata),
        .count_o      (count),
        .empty_o      (empty),
        .full_o       (full)
    );

    // Behavioural SCM: synchronous write, registered read address.
    logic [DW-1:0] mem [4];
    logic [AW-1:0] raddr_q;
    always @(posedge clk) begin
        if (scm_we) mem[scm_waddr] <= scm_wdata;
        if (scm_re) raddr_q <= scm_raddr;
    end
    assign scm_rdata = mem[raddr_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop everything in exp_q in order, bounded by a cycle budget.
    task automatic drain(input string tag);
        int budget;
        budget = 0;
        pop_ready = 1'b1;
        while (exp_q.size() > 0 && budget < 30) begin
            #1;
            if (pop_valid) chk(tag, pop_data, exp_q.pop_front());
            tick();
            budget++;
        end
        chk({tag, "_done"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        pop_ready = 1'b0;
    endtask

    initial begin
        int sent, got, first, last;
        rst = 1'b1;
`ifdef HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN
        clear_i = 1'b0;
`endif
        push_valid = 1'b1;
        push_data = 32'h0;
        pop_ready = 1'b0;
        #3;
        // Reset state, with push_valid high to show no write leaks through.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pready", 32'(push_ready), 32'd1);
        chk("rst_pvalid", 32'(pop_valid), 32'd0);
        chk("rst_we", 32'(scm_we), 32'd0);
        chk("rst_re", 32'(scm_re), 32'd0);
        push_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single word fall-through latency.
        push_valid = 1'b1; push_data = 32'hA5; pop_ready = 1'b1;
        #1;
        chk("ft_we", 32'(scm_we), 32'd1);
        chk("ft_waddr", 32'(scm_waddr), 32'd0);
        chk("ft_wdata", scm_wdata, 32'hA5);
        chk("ft_re0", 32'(scm_re), 32'd0);
        tick();
        push_valid = 1'b0;
        #1;
        chk("ft_re1", 32'(scm_re), 32'd1);
        chk("ft_raddr", 32'(scm_raddr), 32'd0);
        chk("ft_pv1", 32'(pop_valid), 32'd0);
        chk("ft_cnt1", 32'(count), 32'd1);
        tick();
        #1;
        chk("ft_pv2", 32'(pop_valid), 32'd1);
        chk("ft_data", pop_data, 32'hA5);
        tick();
        #1;
        chk("ft_pv3", 32'(pop_valid), 32'd0);
        chk("ft_empty", 32'(empty), 32'd1);

        // Fill to full with downstream stalled; head word must stay put.
        pop_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_valid = 1'b1;
            push_data = (i < 4) ? 32'(i + 1) : 32'd5;
            #1;
            if (i >= 2) chk("stall_data", pop_data, 32'd1);
            if (i >= 4) begin
                chk("full_flag", 32'(full), 32'd1);
                chk("full_cnt", 32'(count), 32'd4);
                chk("full_pready", 32'(push_ready), 32'd0);
                chk("full_we", 32'(scm_we), 32'd0);
            end
            tick();
        end
        // Pop at full with a push pending: push still refused this cycle.
        pop_ready = 1'b1; push_valid = 1'b1; push_data = 32'd5;
        #1;
        chk("pp_we", 32'(scm_we), 32'd0);
        chk("pp_pv", 32'(pop_valid), 32'd1);
        chk("pp_data", pop_data, 32'd1);
        chk("pp_re", 32'(scm_re), 32'd1);
        tick();
        push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        chk("pp_cnt", 32'(count), 32'd3);
        chk("pp_pready", 32'(push_ready), 32'd1);
        chk("pp_next", pop_data, 32'd2);
        tick();
        exp_q = '{32'd2, 32'd3, 32'd4};
        drain("full_drain");
        chk("drain_empty", 32'(empty), 32'd1);

        // Streaming 0..9 through the FIFO with pointer wrap.
        sent = 0; got = 0; first = -1; last = -1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            push_valid = (sent < 10);
            push_data = 32'(sent);
            pop_ready = 1'b1;
            #1;
            if (push_valid && push_ready) sent++;
            if (pop_valid) begin
                chk("stream_data", pop_data, 32'(got));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            tick();
        end
        push_valid = 1'b0; pop_ready = 1'b0;
        chk("stream_got", 32'(got), 32'd10);
        chk("stream_gapless", 32'(last - first), 32'd9);
        chk("stream_first", 32'(first), 32'd2);

        // Asynchronous reset with contents in flight.
        for (int i = 0; i < 5; i++) begin
            push_valid = (i < 3);
            push_data = 32'(16 + i);
            tick();
        end
        push_valid = 1'b0;
        #1;
        chk("pre_rst_cnt", 32'(count), 32'd3);
        chk("pre_rst_pv", 32'(pop_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_pv", 32'(pop_valid), 32'd0);
        chk("mid_rst_pready", 32'(push_ready), 32'd1);
        chk("mid_rst_we", 32'(scm_we), 32'd0);
        chk("mid_rst_re", 32'(scm_re), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        push_valid = 1'b1; push_data = 32'h77;
        #1;
        chk("post_rst_waddr", 32'(scm_waddr), 32'd0);
        tick();
        push_valid = 1'b0;
        exp_q = '{32'h77};
        drain("post_rst");

`ifdef HWPE_STREAM_FIFO_SCM_CTRL_CLEAR_EN
        // Clear overrides a coincident push and pop.
        for (int i = 0; i < 3; i++) begin
            push_valid = (i < 2);
            push_data = 32'(32 + i);
            tick();
        end
        clear_i = 1'b1; push_valid = 1'b1; push_data = 32'h99; pop_ready = 1'b1;
        #1;
        chk("clr_pready", 32'(push_ready), 32'd0);
        chk("clr_we", 32'(scm_we), 32'd0);
        tick();
        clear_i = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        chk("clr_cnt", 32'(count), 32'd0);
        chk("clr_pv", 32'(pop_valid), 32'd0);
        push_valid = 1'b1; push_data = 32'h33;
        #1;
        chk("clr_waddr", 32'(scm_waddr), 32'd0);
        tick();
        push_valid = 1'b0;
        exp_q = '{32'h33};
        drain("post_clr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
